// File: rtl/apa102_pkg.sv
// Shared constants for the APA102 frame path: header marker, payload layout
// and FSM state encoding, plus the per-payload header test.
package apa102_pkg;

    localparam logic [2:0] HDR_MARK   = 3'b111;
    localparam int         LED_BITS   = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_SEND    = 2'd2;
    localparam logic [1:0] ST_BLANK   = 2'd3;

    localparam int         BRIGHT_LSB = 24;
    localparam int         BLUE_LSB   = 16;
    localparam int         GREEN_LSB  = 8;

    // A payload is well formed when its three top bits carry the marker.
    function automatic logic hdr_ok_f(input logic [LED_BITS-1:0] payload);
        return (payload[LED_BITS-1 -: 3] == HDR_MARK);
    endfunction

endpackage

// File: rtl/apa102_payload_decode.sv
// Splits one 32-bit LED payload into brightness and colour fields.
// With blank set, all fields are forced to zero (used for blanking and idle).
module apa102_payload_decode
    import apa102_pkg::*;
(
    input  logic [LED_BITS-1:0] payload,
    input  logic                blank,
    output logic                hdr_ok,
    output logic [4:0]          bright,
    output logic [7:0]          blue,
    output logic [7:0]          green,
    output logic [7:0]          red
);

    // Field extraction with optional forced-zero colour.
    always_comb begin
        hdr_ok = hdr_ok_f(payload);
        if (blank) begin
            bright = 5'd0;
            blue   = 8'd0;
            green  = 8'd0;
            red    = 8'd0;
        end else begin
            bright = payload[BRIGHT_LSB +: 5];
            blue   = payload[BLUE_LSB +: 8];
            green  = payload[GREEN_LSB +: 8];
            red    = payload[GREEN_LSB-1:0];
        end
    end

endmodule

// File: rtl/apa102_frame_ctrl.sv
// Frame controller behind the APA102 SPI receiver: validates completed frames,
// double-buffers them (pending -> shadow), streams LEDs one by one over a
// valid/ready handshake and blanks the string once when the source goes quiet.
module apa102_frame_ctrl
    import apa102_pkg::*;
#(
    parameter int N_LEDS         = 7,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LED_BITS*N_LEDS-1:0]   frame_data,
    input  logic                         frame_done,
    output logic                         led_valid,
    input  logic                         led_ready,
    output logic [2:0]                   led_index,
    output logic [4:0]                   led_bright,
    output logic [7:0]                   led_blue,
    output logic [7:0]                   led_green,
    output logic [7:0]                   led_red,
    output logic                         frame_err,
    output logic                         overrun,
    output logic                         stale
);

    localparam int               FW       = LED_BITS * N_LEDS;
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_MAX   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WD_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       IDX_LAST = 3'(N_LEDS - 1);

    logic [1:0]          state_r, state_nxt_s;
    logic [2:0]          idx_r, idx_nxt_s;
    logic [FW-1:0]       shadow_r, shadow_nxt_s, pend_frame_r;
    logic                pending_r, pend_clr_s;
    logic [CNT_W-1:0]    wdog_r;
    logic                stale_r, stale_set_s;
    logic                hdr_all_ok_s, accept_s, reject_s, handshake_s, valid_nxt_s;
    logic [LED_BITS-1:0] sel_payload_s;
    logic                dec_hdr_unused_s;
    logic [4:0]          dec_bright_s;
    logic [7:0]          dec_blue_s, dec_green_s, dec_red_s;
    logic                led_valid_r, frame_err_r, overrun_r;
    logic [2:0]          led_index_r;
    logic [4:0]          led_bright_r;
    logic [7:0]          led_blue_r, led_green_r, led_red_r;

    // Frame is accepted only if every LED payload carries the header marker.
    always_comb begin
        hdr_all_ok_s = 1'b1;
        for (int i = 0; i < N_LEDS; i++) begin
            hdr_all_ok_s = hdr_all_ok_s & hdr_ok_f(frame_data[FW-1-LED_BITS*i -: LED_BITS]);
        end
    end

    assign accept_s    = frame_done & hdr_all_ok_s;
    assign reject_s    = frame_done & ~hdr_all_ok_s;
    assign handshake_s = led_valid_r & led_ready;

    // Sequencer next state; an accept in IDLE goes straight to LOAD so LED0
    // appears two cycles after frame_done.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        shadow_nxt_s = shadow_r;
        pend_clr_s   = 1'b0;
        stale_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pending_r || accept_s) begin
                    state_nxt_s = ST_LOAD;
                end else if (!stale_r && (wdog_r == WD_LAST)) begin
                    state_nxt_s = ST_BLANK;
                    idx_nxt_s   = 3'd0;
                    stale_set_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shadow_nxt_s = pend_frame_r;
                pend_clr_s   = 1'b1;
                idx_nxt_s    = 3'd0;
                state_nxt_s  = ST_SEND;
            end
            ST_SEND, ST_BLANK: begin
                if (handshake_s) begin
                    if (idx_r == IDX_LAST) begin
                        state_nxt_s = ST_IDLE;
                        idx_nxt_s   = 3'd0;
                    end else begin
                        idx_nxt_s   = idx_r + 3'd1;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 3'd0;
            end
        endcase
    end

    assign valid_nxt_s = (state_nxt_s == ST_SEND) || (state_nxt_s == ST_BLANK);

    // Pick the payload that will be on the outputs next cycle.
    always_comb begin
        sel_payload_s = {LED_BITS{1'b0}};
        for (int i = 0; i < N_LEDS; i++) begin
            sel_payload_s = sel_payload_s |
                (shadow_nxt_s[FW-1-LED_BITS*i -: LED_BITS] & {LED_BITS{idx_nxt_s == 3'(i)}});
        end
    end

    apa102_payload_decode u_decode (
        .payload (sel_payload_s),
        .blank   (state_nxt_s != ST_SEND),
        .hdr_ok  (dec_hdr_unused_s),
        .bright  (dec_bright_s),
        .blue    (dec_blue_s),
        .green   (dec_green_s),
        .red     (dec_red_s)
    );

    // Sequencer state, LED index and shadow buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= 3'd0;
            shadow_r <= {FW{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            idx_r    <= idx_nxt_s;
            shadow_r <= shadow_nxt_s;
        end
    end

    // Pending frame register plus the error/overrun pulses; a new accept wins
    // over the clear from LOAD, and replacing a frame LOAD is taking is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_frame_r <= {FW{1'b0}};
            pending_r    <= 1'b0;
            overrun_r    <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                pend_frame_r <= frame_data;
                pending_r    <= 1'b1;
            end else if (pend_clr_s) begin
                pending_r    <= 1'b0;
            end else begin
                pending_r    <= pending_r;
            end
            overrun_r   <= accept_s & pending_r & ~pend_clr_s;
            frame_err_r <= reject_s;
        end
    end

    // Silence watchdog: counts idle cycles, saturates, and raises stale once.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_r  <= {CNT_W{1'b0}};
            stale_r <= 1'b0;
        end else if (accept_s) begin
            wdog_r  <= {CNT_W{1'b0}};
            stale_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && !stale_r && (wdog_r < WD_MAX)) begin
                wdog_r <= wdog_r + WD_ONE;
            end else begin
                wdog_r <= wdog_r;
            end
            stale_r <= stale_r | stale_set_s;
        end
    end

    // Registered LED payload outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_valid_r  <= 1'b0;
            led_index_r  <= 3'd0;
            led_bright_r <= 5'd0;
            led_blue_r   <= 8'd0;
            led_green_r  <= 8'd0;
            led_red_r    <= 8'd0;
        end else begin
            led_valid_r  <= valid_nxt_s;
            led_index_r  <= valid_nxt_s ? idx_nxt_s : 3'd0;
            led_bright_r <= dec_bright_s;
            led_blue_r   <= dec_blue_s;
            led_green_r  <= dec_green_s;
            led_red_r    <= dec_red_s;
        end
    end

    assign led_valid  = led_valid_r;
    assign led_index  = led_index_r;
    assign led_bright = led_bright_r;
    assign led_blue   = led_blue_r;
    assign led_green  = led_green_r;
    assign led_red    = led_red_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign stale      = stale_r;

endmodule

// File: tb/tb_apa102_frame_ctrl.sv
// Randomised + directed bench for apa102_frame_ctrl against a reference model
// built from the frame/handshake/watchdog rules.
module tb_apa102_frame_ctrl;

    localparam int N  = 7;
    localparam int T  = 100;
    localparam int CW = 8;
    localparam int FW = 32 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] frame_data;
    logic          frame_done;
    logic          led_valid;
    logic          led_ready;
    logic [2:0]    led_index;
    logic [4:0]    led_bright;
    logic [7:0]    led_blue, led_green, led_red;
    logic          frame_err, overrun, stale;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apa102_frame_ctrl #(.N_LEDS(N), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_data (frame_data),
        .frame_done (frame_done),
        .led_valid  (led_valid),
        .led_ready  (led_ready),
        .led_index  (led_index),
        .led_bright (led_bright),
        .led_blue   (led_blue),
        .led_green  (led_green),
        .led_red    (led_red),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .stale      (stale)
    );

    // Reference model state (describes the current cycle's outputs)
    logic [FW-1:0] m_pend_frame, m_seq_frame;
    bit m_pend, m_loading, m_valid, m_blank, m_stale, m_err, m_ovr, m_after_rst;
    int m_idx, m_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [FW-1:0] f, input int i);
        logic [FW-1:0] sh;
        sh = f >> (32 * (N - 1 - i));
        return sh[31:0];
    endfunction

    function automatic bit hdr_good(input logic [FW-1:0] f);
        for (int i = 0; i < N; i++) begin
            if ((word_of(f, i) >> 29) != 32'd7) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [FW-1:0] mk_frame(input int bad_led);
        logic [FW-1:0] f;
        logic [31:0]   w;
        f = '0;
        for (int i = 0; i < N; i++) begin
            w = $urandom;
            w[31:29] = 3'b111;
            if (i == bad_led) w[31:29] = 3'($urandom_range(0, 6));
            f = (f << 32) | FW'(w);
        end
        return f;
    endfunction

    function automatic logic [FW-1:0] basic_frame();
        logic [FW-1:0] f;
        logic [31:0]   w;
        f = '0;
        for (int i = 0; i < N; i++) begin
            w = {3'b111, 5'd31, 8'(16 * i), 8'h20, 8'h30};
            f = (f << 32) | FW'(w);
        end
        return f;
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_edge(input bit fd, input logic [FW-1:0] d, input bit rdy, input bit r);
        bit ok, was_idle, old_stale;
        if (r) begin
            m_pend = 0; m_loading = 0; m_valid = 0; m_blank = 0; m_stale = 0;
            m_err = 0; m_ovr = 0; m_idx = 0; m_wd = 0; m_after_rst = 1;
            m_pend_frame = '0; m_seq_frame = '0;
            return;
        end
        m_after_rst = 0;
        ok        = fd && hdr_good(d);
        m_err     = fd && !ok;
        m_ovr     = ok && m_pend && !m_loading;
        was_idle  = !m_valid && !m_loading;
        old_stale = m_stale;
        if (m_loading) begin
            m_seq_frame = m_pend_frame;
            m_blank = 0; m_idx = 0; m_valid = 1; m_loading = 0; m_pend = 0;
        end else if (m_valid) begin
            if (rdy) begin
                if (m_idx == N - 1) m_valid = 0;
                else m_idx++;
            end
        end else if (m_pend || ok) begin
            m_loading = 1;
        end else if (!old_stale && m_wd == T - 1) begin
            m_valid = 1; m_blank = 1; m_idx = 0; m_stale = 1;
        end
        if (ok) begin
            m_wd = 0; m_stale = 0; m_pend = 1; m_pend_frame = d;
        end else if (was_idle && !old_stale && m_wd < T) begin
            m_wd++;
        end
    endtask

    // One cycle: check outputs at negedge, drive inputs, then take the edge.
    task automatic step(input bit fd, input logic [FW-1:0] d, input bit rdy, input bit r);
        logic [31:0] w;
        @(negedge clk);
        chk("led_valid", {31'd0, led_valid}, {31'd0, m_valid});
        if (m_valid) begin
            w = m_blank ? 32'd0 : word_of(m_seq_frame, m_idx);
            chk("led_index",  {29'd0, led_index},  m_idx);
            chk("led_bright", {27'd0, led_bright}, (w >> 24) & 32'd31);
            chk("led_blue",   {24'd0, led_blue},   (w >> 16) & 32'd255);
            chk("led_green",  {24'd0, led_green},  (w >> 8) & 32'd255);
            chk("led_red",    {24'd0, led_red},    w & 32'd255);
        end else if (m_after_rst) begin
            chk("rst_fields", {8'd0, led_index, led_bright, led_blue, led_green}, 32'd0);
            chk("rst_red", {24'd0, led_red}, 32'd0);
        end
        chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
        chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
        chk("stale",     {31'd0, stale},     {31'd0, m_stale});
        frame_done = fd;
        frame_data = d;
        led_ready  = rdy;
        rst        = r;
        model_edge(fd, d, rdy, r);
        @(posedge clk);
    endtask

    initial begin
        logic [FW-1:0] f;
        bit            fd;
        rst = 1'b1; frame_done = 1'b0; frame_data = '0; led_ready = 1'b0;
        model_edge(1'b0, '0, 1'b0, 1'b1);
        // Reset state
        step(0, '0, 0, 1);
        step(0, '0, 1, 0);
        // Basic send
        step(1, basic_frame(), 1, 0);
        repeat (12) step(0, '0, 1, 0);
        // Backpressure at LED 3
        step(1, mk_frame(-1), 1, 0);
        repeat (4) step(0, '0, 1, 0);
        repeat (5) step(0, '0, 0, 0);
        repeat (10) step(0, '0, 1, 0);
        // Header error on LED4, then a good frame
        step(1, mk_frame(4), 1, 0);
        repeat (5) step(0, '0, 1, 0);
        step(1, mk_frame(-1), 1, 0);
        repeat (12) step(0, '0, 1, 0);
        // Pending / overrun: A, B, C during X
        step(1, mk_frame(-1), 0, 0);
        repeat (3) step(0, '0, 0, 0);
        step(1, mk_frame(-1), 0, 0);
        step(0, '0, 0, 0);
        step(1, mk_frame(-1), 0, 0);
        step(0, '0, 0, 0);
        step(1, mk_frame(-1), 0, 0);
        repeat (3) step(0, '0, 0, 0);
        repeat (30) step(0, '0, 1, 0);
        // Watchdog: blank once, no repeat, cleared by a valid frame
        repeat (T + 20) step(0, '0, 1, 0);
        repeat (150) step(0, '0, 1, 0);
        step(1, mk_frame(-1), 1, 0);
        repeat (12) step(0, '0, 1, 0);
        // Reset while LED 2 is on the outputs
        step(1, mk_frame(-1), 1, 0);
        repeat (3) step(0, '0, 1, 0);
        step(0, '0, 1, 1);
        step(1, mk_frame(-1), 1, 0);
        repeat (12) step(0, '0, 1, 0);
        // Randomised traffic with periodic quiet windows
        for (int c = 0; c < 3000; c++) begin
            f  = mk_frame(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1);
            fd = ((c % 1000) < 880) && ($urandom_range(0, 9) == 0);
            step(fd, f, $urandom_range(0, 3) != 0, ($urandom_range(0, 499) == 0));
        end
        step(0, '0, 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apa102_frame_ctrl.md
Name: apa102_frame_ctrl

Overview:
Controller downstream of the APA102 SPI receiver. Validates each completed 224-bit, 7-LED frame and latches it into a shadow buffer. Then issues the LEDs one at a time to the PWM/driver stage over a valid/ready handshake. A watchdog blanks the LEDs, by sending one all-zero sequence, when the SPI source goes silent.

Parameters:
N_LEDS, 7, LEDs per frame; frame width is 32*N_LEDS bits.
TIMEOUT_CYCLES, 1000000, clk cycles without a valid frame before blanking.
CNT_W, 20, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
frame_data  in  32*N_LEDS  receiver frame; LED0 in MSBs [32*N_LEDS-1 -: 32]
frame_done  in  1  one-cycle strobe: receiver finished the data phase; frame_data stable that cycle
led_valid  out  1  payload outputs valid
led_ready  in  1  consumer accepts when led_valid && led_ready
led_index  out  3  LED number 0..N_LEDS-1
led_bright  out  5  global brightness, payload bits [28:24]
led_blue  out  8  payload [23:16]
led_green  out  8  payload [15:8]
led_red  out  8  payload [7:0]
frame_err  out  1  one-cycle pulse: header check failed, frame dropped
overrun  out  1  one-cycle pulse: pending frame overwritten before it was consumed
stale  out  1  level: watchdog expired; cleared by the next valid frame

Behaviour:
- Reset values: all outputs 0; shadow buffer 0; pending 0; watchdog 0; state IDLE.
- Reset asserted mid-sequence: led_valid drops the cycle after rst is sampled; nothing in flight survives.
- Header check on frame_done: every LED payload's bits [31:29] must equal 3'b111.
  - Pass: the frame is written to the pending register, pending is set, and the watchdog clears.
  - Fail: frame_err pulses the next cycle; the frame, pending and the watchdog are all untouched.
- Overrun: frame_done passes while pending is already set → the new frame overwrites pending and overrun pulses.
- FSM states: IDLE, LOAD, SEND, BLANK.
  - IDLE → LOAD when pending = 1.
  - IDLE → BLANK when the watchdog reaches TIMEOUT_CYCLES and stale = 0. stale is set on the same edge.
  - LOAD (1 cycle): pending is copied to the shadow, pending is cleared, idx = 0 → SEND.
  - SEND: led_valid = 1, outputs are decoded from shadow[idx].
    - Outputs are held stable while led_ready = 0.
    - On handshake, idx increments.
    - Handshake at idx = N_LEDS-1 → IDLE, with led_valid = 0 the next cycle.
  - BLANK: same as SEND, but bright/colour are forced to 0 and idx still runs 0..N_LEDS-1 → IDLE.
    - A valid frame arriving during BLANK only sets pending; BLANK completes before LOAD.
- Latency: valid frame_done at cycle t with FSM in IDLE → LOAD at t+1 → led_valid = 1 at t+2 for LED0.
- Frame accepted during SEND: it only updates pending, and the shadow is unaffected. That frame is sent after the current sequence ends (IDLE → LOAD).
- Simultaneous: frame_done on the same cycle as the final SEND handshake → pending is set. IDLE sees it on the next cycle, so there is no lost frame.
- Watchdog:
  - Increments each cycle while state is IDLE and stale = 0.
  - Saturates at TIMEOUT_CYCLES.
  - Clears on any valid frame.
  - stale stays 1 with no repeated blanking until a valid frame arrives; that frame clears stale on acceptance.

Decomposition:
- Shared package apa102_pkg:
  - constants HDR_MARK = 3'b111, LED_BITS = 32
  - FSM state encoding (IDLE = 0, LOAD = 1, SEND = 2, BLANK = 3)
  - field offsets BRIGHT_LSB = 24, BLUE_LSB = 16, GREEN_LSB = 8
- One sub-module, apa102_payload_decode: combinational; 32-bit payload plus a blank flag in → hdr_ok, bright, blue, green, red out.
  - One instance drives the outputs.
  - The header check uses N_LEDS hdr_ok results, via a generate loop or an inline reduction.

Test Plan:
- Basic send: all 7 payloads = {3'b111, 5'd31, 8'h10*i, 8'h20, 8'h30}, pulse frame_done, led_ready = 1 → led_valid at t+2, led_index 0..6 on consecutive cycles, led_blue = 8'h00, 8'h10 … 8'h60, then led_valid = 0.
- Backpressure: led_ready = 0 for 5 cycles at LED 3 → index 3 and its fields stay constant for 5 cycles; total sequence = 7 handshakes, no skip or duplicate.
- Header error: LED4 header 3'b110 → frame_err pulse at t+1, no led_valid, previous shadow retained; a next good frame sends normally.
- Pending/overrun: frames A, B, C accepted during the sequence of frame X (led_ready = 0) → overrun pulses on C; after X, C is sent and B is never sent.
- Watchdog: TIMEOUT_CYCLES = 100, no frames → stale = 1 at cycle 100; 7 all-zero payloads sent exactly once; a later valid frame clears stale and is sent.
- Reset mid-SEND: rst asserted at index 2 → next cycle led_valid = 0, stale = 0, the new frame's sequence starts at index 0.
